// File: rtl/if_pkg.sv
// Shared instruction field layout, decoded-field bundle and stage states
// for the fetch/decode stream and the stages that consume its output.
package if_pkg;

  localparam int IMM_BIT = 25;
  localparam int OPC_HI  = 24;
  localparam int OPC_LO  = 21;
  localparam int SF_BIT  = 20;
  localparam int RN_HI   = 19;
  localparam int RN_LO   = 16;
  localparam int RD_HI   = 15;
  localparam int RD_LO   = 12;
  localparam int SR_HI   = 11;
  localparam int SR_LO   = 4;
  localparam int SI_HI   = 11;
  localparam int SI_LO   = 8;
  localparam int RM_HI   = 3;
  localparam int RM_LO   = 0;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  // sft_reg, sft_imm and imm deliberately overlap; execute picks one
  typedef struct packed {
    logic       imm_or_reg;
    logic [3:0] op_code;
    logic       set_flags;
    logic [3:0] op_reg1;
    logic [3:0] dest;
    logic [7:0] sft_reg;
    logic [3:0] sft_imm;
    logic [3:0] op_reg2;
    logic [7:0] imm;
  } decoded_t;

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/instr_field_decode.sv
// Pure bit-slice decode of one instruction word into its operand fields.
module instr_field_decode
  import if_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] word,
  output decoded_t          dec
);

  always_comb begin
    dec            = '0;
    dec.imm_or_reg = word[IMM_BIT];
    dec.op_code    = word[OPC_HI:OPC_LO];
    dec.set_flags  = word[SF_BIT];
    dec.op_reg1    = word[RN_HI:RN_LO];
    dec.dest       = word[RD_HI:RD_LO];
    dec.sft_reg    = word[SR_HI:SR_LO];
    dec.sft_imm    = word[SI_HI:SI_LO];
    dec.op_reg2    = word[RM_HI:RM_LO];
    dec.imm        = word[IMM_HI:IMM_LO];
  end

  // bits above the field map are reserved for wider encodings
  if (WORD_W > 26) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^word[WORD_W-1:26];
  end

endmodule

// File: rtl/if_decode_stream.sv
// Fetch/decode stage: loadable imem, self-incrementing PC with redirect,
// decoded fields presented through a one-entry valid/ready register.
module if_decode_stream
  import if_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16,
  localparam int PC_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_waddr,
  input  logic [WORD_W-1:0] imem_wdata,
  input  logic              run,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic              imm_or_reg,
  output logic [3:0]        op_code,
  output logic              set_flags,
  output logic [3:0]        op_reg1,
  output logic [3:0]        dest,
  output logic [7:0]        sft_reg,
  output logic [3:0]        sft_imm,
  output logic [3:0]        op_reg2,
  output logic [7:0]        imm,
  output logic              busy,
  output logic [CNT_W-1:0]  instr_count
);

  if (WORD_W < 26) begin : g_chk_w
    $error("WORD_W must be at least 26");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_d
    $error("DEPTH must be a power of two and at least 2");
  end

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PC_W-1:0]   pc;
  state_t            state;
  decoded_t          dec_next, fields;
  logic              fetch, accept;

  // no reset on the array: program survives a stage reset
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  instr_field_decode #(.WORD_W(WORD_W)) u_dec (
    .word (mem[pc]),
    .dec  (dec_next)
  );

  assign fetch  = (state == RUN) && run && !redirect_valid && (!out_valid || out_ready);
  assign accept = out_valid && out_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= '0;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      fields      <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE: if (run)  state <= RUN;
        RUN:  if (!run) state <= IDLE;
        default:        state <= IDLE;
      endcase

      if (redirect_valid) begin
        pc        <= redirect_pc;
        out_valid <= 1'b0;
      end else if (fetch) begin
        fields    <= dec_next;
        out_pc    <= pc;
        out_valid <= 1'b1;
        pc        <= pc + PC_W'(1);
      end else if (out_ready && out_valid) begin
        out_valid <= 1'b0;
      end

      if (accept && (instr_count != '1)) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign busy       = (state == RUN);
  assign imm_or_reg = fields.imm_or_reg;
  assign op_code    = fields.op_code;
  assign set_flags  = fields.set_flags;
  assign op_reg1    = fields.op_reg1;
  assign dest       = fields.dest;
  assign sft_reg    = fields.sft_reg;
  assign sft_imm    = fields.sft_imm;
  assign op_reg2    = fields.op_reg2;
  assign imm        = fields.imm;

endmodule
